mbus_arb: RTL and testbench
===========================

# mbus_arb

Two-master arbiter for the 16-bit-address / 32-bit-data register bus (MAD/MDI/MBE/MWE/MRE/MDO) in the MCK domain. It sits between the I2C slave front end (port A) and a second host master (port B), and the single register bank (BUS side). Each master issues one-cycle write or read strobes, which are buffered one deep per port. A round-robin FSM serialises the buffered requests onto the bus, then returns an acknowledge and, for reads, the read data to the originating port.

## Interface
- RD_LAT, 1: cycles from the BUS_MRE strobe cycle to the cycle BUS_MDO is valid. Legal range is 1..7.

Ports:
- MCK  in  1  sole clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- A_MAD / B_MAD  in  16  request address.
- A_MDI / B_MDI  in  32  write data.
- A_MBE / B_MBE  in  32  write byte/bit enables.
- A_MWE / B_MWE  in  1  one-cycle write request pulse.
- A_MRE / B_MRE  in  1  one-cycle read request pulse.
- A_MDO / B_MDO  out  32  read data, held until that port's next read completes.
- A_ACK / B_ACK  out  1  one-cycle completion pulse.
- BUS_MAD  out  16  bus address.
- BUS_MDI  out  32  bus write data.
- BUS_MBE  out  32  bus enables.
- BUS_MWE  out  1  bus write strobe.
- BUS_MRE  out  1  bus read strobe.
- BUS_MDO  in  32  bus read data.
- ERR_CLR  in  1  clears ERR.
- ERR  out  2  sticky drop flags: [0]=A, [1]=B.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- Per-port pending buffer: a valid bit plus latched MAD/MDI/MBE and a write flag.
  - Loads on a MWE|MRE pulse when the buffer is empty, or in that port's DONE cycle (set overrides clear).
  - MWE and MRE high together: taken as a write; the read is dropped and the port's ERR bit is set.
  - A pulse while the buffer is valid and not in DONE: the request is dropped and the port's ERR bit is set.
- ERR_CLR clears both ERR bits. If ERR_CLR and a new drop occur in the same cycle, the set wins.
- FSM states:
  - IDLE: if any buffer is valid, grant a port and go to ISSUE.
  - ISSUE: one cycle; BUS_MWE or BUS_MRE is high. A write goes to DONE; a read goes to WAIT.
  - WAIT: RD_LAT cycles, then DONE.
  - DONE: one cycle; the granted port's ACK is high and its buffer is cleared. Go to IDLE.
- Arbitration is round-robin on a LAST pointer, reset to B so that A wins first.
  - If both ports are valid, grant the port not equal to LAST.
  - If one port is valid, grant it.
  - LAST updates on each grant.
- BUS_MAD/MDI/MBE are registered from the granted buffer on entry to ISSUE and held until the next grant.
  - BUS_MBE is forced to 0 for reads.
  - BUS_MWE and BUS_MRE are decoded from the registered state and are never high together.
- Read data: BUS_MDO is captured into the granted port's MDO register at the end of the last WAIT cycle.
- Reset values: BUS_MAD=16'hFFFF, BUS_MDI=32'hFFFFFFFF, BUS_MBE=0, BUS_MWE=BUS_MRE=0, A_MDO=B_MDO=0, ACKs=0, ERR=0, BUSY=0, state=IDLE, buffers empty.
- Reset asserted mid-transaction aborts immediately. Strobes and ACKs fall asynchronously and pending requests are lost.

## Timing
- Request pulse in cycle t:
  - buffer valid in t+1;
  - ISSUE (bus strobe) in t+2, if the FSM was in IDLE at t+1.
- Write: ACK in t+3; FSM back in IDLE at t+4.
- Read:
  - WAIT spans t+3..t+2+RD_LAT;
  - BUS_MDO is sampled in cycle t+2+RD_LAT;
  - ACK and the new MDO value appear in t+3+RD_LAT.
- Minimum bus spacing: 3 cycles between write strobes, 3+RD_LAT cycles between read strobes.
- A request arriving during another port's service waits, then issues 2 cycles after the current DONE (IDLE, then ISSUE).

## Test plan
- Single write on A (MAD=16'h0012, MDI=32'hCAFE0001) at t: BUS_MWE=1 at t+2 with the same address and data and BUS_MBE=A_MBE; A_ACK at t+3; B_ACK stays 0.
- Read on B with RD_LAT=3, bus returning 32'h5A5A1234: BUS_MRE at t+2 with BUS_MBE=0; B_MDO=32'h5A5A1234 and B_ACK both at t+6; A_MDO unchanged.
- A write and B write in the same cycle after reset: A is serviced first (strobe t+2, ACK t+3), then B (strobe t+5, ACK t+6). Repeat the same simultaneous pair: B goes first.
- Second A pulse at t+1 while the first A request is pending: ERR=2'b01, only one bus write occurs. ERR_CLR then returns ERR to 0.
- MWE and MRE pulsed together on B: one bus write, ERR[1]=1.
- RSTN low during WAIT of a read: all outputs return to their reset values at once; after release, no ACK is issued and BUS_MRE stays 0.

Source files
------------

// File: rtl/mbus_arb_if.sv
// mbus_arb_if: register-bus signal bundle around the two-master arbiter.
//   A_* / B_*  : request side of master ports A (I2C front end) and B (host).
//                MAD/MDI/MBE/MWE/MRE toward the arbiter, MDO/ACK back.
//   BUS_*      : single register-bank side. MAD/MDI/MBE/MWE/MRE out of the
//                arbiter, MDO read data back into it.
// Modport slave is the arbiter's view; master is the environment's view.
interface mbus_arb_if;
    logic [15:0] A_MAD;
    logic [31:0] A_MDI;
    logic [31:0] A_MBE;
    logic        A_MWE;
    logic        A_MRE;
    logic [31:0] A_MDO;
    logic        A_ACK;

    logic [15:0] B_MAD;
    logic [31:0] B_MDI;
    logic [31:0] B_MBE;
    logic        B_MWE;
    logic        B_MRE;
    logic [31:0] B_MDO;
    logic        B_ACK;

    logic [15:0] BUS_MAD;
    logic [31:0] BUS_MDI;
    logic [31:0] BUS_MBE;
    logic        BUS_MWE;
    logic        BUS_MRE;
    logic [31:0] BUS_MDO;

    modport slave (
        input  A_MAD, A_MDI, A_MBE, A_MWE, A_MRE,
        output A_MDO, A_ACK,
        input  B_MAD, B_MDI, B_MBE, B_MWE, B_MRE,
        output B_MDO, B_ACK,
        output BUS_MAD, BUS_MDI, BUS_MBE, BUS_MWE, BUS_MRE,
        input  BUS_MDO
    );

    modport master (
        output A_MAD, A_MDI, A_MBE, A_MWE, A_MRE,
        input  A_MDO, A_ACK,
        output B_MAD, B_MDI, B_MBE, B_MWE, B_MRE,
        input  B_MDO, B_ACK,
        input  BUS_MAD, BUS_MDI, BUS_MBE, BUS_MWE, BUS_MRE,
        output BUS_MDO
    );
endinterface

// File: rtl/mbus_arb.sv
// mbus_arb: two-master round-robin arbiter for the 16-bit address / 32-bit data
// register bus. Each master's one-cycle strobe is buffered one deep, then
// serialised onto the bus; the originating port gets a one-cycle ACK and, for
// reads, the captured read data.
// Ports:
//   MCK      sole clock, rising edge
//   RSTN     asynchronous active-low reset
//   bus      mbus_arb_if.slave: A_*, B_* master ports and BUS_* bank side
//   ERR_CLR  clears both sticky drop flags
//   ERR      sticky drop flags, [0]=A, [1]=B
//   BUSY     high whenever the FSM is not idle
module mbus_arb #(
    parameter int unsigned RD_LAT = 1  // BUS_MRE cycle to BUS_MDO valid, 1..7
) (
    input  logic        MCK,
    input  logic        RSTN,
    mbus_arb_if.slave   bus,
    input  logic        ERR_CLR,
    output logic [1:0]  ERR,
    output logic        BUSY
);

    localparam logic [2:0] LatLast = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e      state_q;
    logic        gnt_q;      // 0 = A, 1 = B
    logic        last_q;     // last granted port
    logic        op_wr_q;
    logic [2:0]  cnt_q;
    logic [15:0] bus_mad_q;
    logic [31:0] bus_mdi_q;
    logic [31:0] bus_mbe_q;
    logic [31:0] mdo_q [2];

    // Pending request buffers, index 0 = A, 1 = B
    logic [1:0]  buf_vld_q, buf_vld_d;
    logic [1:0]  buf_wr_q;
    logic [15:0] buf_mad_q [2];
    logic [31:0] buf_mdi_q [2];
    logic [31:0] buf_mbe_q [2];

    logic [1:0]  err_q, err_d;

    logic [1:0]  req_we, req_re, done_p, load, err_set;
    logic [15:0] req_mad [2];
    logic [31:0] req_mdi [2];
    logic [31:0] req_mbe [2];
    logic        pick;

    assign req_we     = {bus.B_MWE, bus.A_MWE};
    assign req_re     = {bus.B_MRE, bus.A_MRE};
    assign req_mad[0] = bus.A_MAD;
    assign req_mad[1] = bus.B_MAD;
    assign req_mdi[0] = bus.A_MDI;
    assign req_mdi[1] = bus.B_MDI;
    assign req_mbe[0] = bus.A_MBE;
    assign req_mbe[1] = bus.B_MBE;

    assign done_p[0] = (state_q == StDone) && !gnt_q;
    assign done_p[1] = (state_q == StDone) && gnt_q;

    always_comb begin
        load      = '0;
        err_set   = '0;
        buf_vld_d = buf_vld_q;
        for (int i = 0; i < 2; i++) begin
            // A strobe is accepted when the buffer is free or being freed this cycle
            load[i]    = (req_we[i] | req_re[i]) && (!buf_vld_q[i] || done_p[i]);
            // Overlapping MWE+MRE is taken as a write but still flagged
            err_set[i] = ((req_we[i] | req_re[i]) && buf_vld_q[i] && !done_p[i])
                         || (req_we[i] && req_re[i]);
            if (load[i]) begin
                buf_vld_d[i] = 1'b1;
            end else if (done_p[i]) begin
                buf_vld_d[i] = 1'b0;
            end
        end
        err_d = (ERR_CLR ? 2'b00 : err_q) | err_set;
    end

    // Both pending: alternate away from the last grant; otherwise take whichever is valid
    assign pick = (buf_vld_q[0] && buf_vld_q[1]) ? ~last_q : buf_vld_q[1];

    always_ff @(posedge MCK or negedge RSTN) begin
        if (!RSTN) begin
            buf_vld_q <= '0;
            buf_wr_q  <= '0;
            err_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_mad_q[i] <= '0;
                buf_mdi_q[i] <= '0;
                buf_mbe_q[i] <= '0;
            end
        end else begin
            buf_vld_q <= buf_vld_d;
            err_q     <= err_d;
            for (int i = 0; i < 2; i++) begin
                if (load[i]) begin
                    buf_wr_q[i]  <= req_we[i];
                    buf_mad_q[i] <= req_mad[i];
                    buf_mdi_q[i] <= req_mdi[i];
                    buf_mbe_q[i] <= req_mbe[i];
                end
            end
        end
    end

    always_ff @(posedge MCK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= StIdle;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;  // A wins the first contest
            op_wr_q   <= 1'b0;
            cnt_q     <= '0;
            bus_mad_q <= 16'hFFFF;
            bus_mdi_q <= 32'hFFFF_FFFF;
            bus_mbe_q <= '0;
            mdo_q[0]  <= '0;
            mdo_q[1]  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|buf_vld_q) begin
                        gnt_q     <= pick;
                        last_q    <= pick;
                        op_wr_q   <= buf_wr_q[pick];
                        bus_mad_q <= buf_mad_q[pick];
                        bus_mdi_q <= buf_mdi_q[pick];
                        bus_mbe_q <= buf_wr_q[pick] ? buf_mbe_q[pick] : 32'h0;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= op_wr_q ? StDone : StWait;
                end
                StWait: begin
                    if (cnt_q == LatLast) begin
                        mdo_q[gnt_q] <= bus.BUS_MDO;
                        state_q      <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Strobes and ACKs decode straight from state so reset drops them at once
    assign bus.BUS_MWE = (state_q == StIssue) && op_wr_q;
    assign bus.BUS_MRE = (state_q == StIssue) && !op_wr_q;
    assign bus.BUS_MAD = bus_mad_q;
    assign bus.BUS_MDI = bus_mdi_q;
    assign bus.BUS_MBE = bus_mbe_q;
    assign bus.A_ACK   = done_p[0];
    assign bus.B_ACK   = done_p[1];
    assign bus.A_MDO   = mdo_q[0];
    assign bus.B_MDO   = mdo_q[1];
    assign ERR         = err_q;
    assign BUSY        = (state_q != StIdle);

endmodule

// File: tb/tb_mbus_arb.sv
// tb_mbus_arb: directed bench for mbus_arb with RD_LAT = 3.
module tb_mbus_arb;

    logic       MCK;
    logic       RSTN;
    logic       ERR_CLR;
    logic [1:0] ERR;
    logic       BUSY;

    int vectors;
    int miscompares;

    mbus_arb_if bus_if ();

    mbus_arb #(
        .RD_LAT (3)
    ) dut (
        .MCK     (MCK),
        .RSTN    (RSTN),
        .bus     (bus_if),
        .ERR_CLR (ERR_CLR),
        .ERR     (ERR),
        .BUSY    (BUSY)
    );

    initial MCK = 1'b0;
    always #5 MCK = ~MCK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge MCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " BUS_MAD"}, {16'h0, bus_if.BUS_MAD}, 32'h0000FFFF);
        chk({tag, " BUS_MDI"}, bus_if.BUS_MDI, 32'hFFFFFFFF);
        chk({tag, " BUS_MBE"}, bus_if.BUS_MBE, 32'h0);
        chk({tag, " BUS_MWE"}, {31'h0, bus_if.BUS_MWE}, 32'h0);
        chk({tag, " BUS_MRE"}, {31'h0, bus_if.BUS_MRE}, 32'h0);
        chk({tag, " A_MDO"}, bus_if.A_MDO, 32'h0);
        chk({tag, " B_MDO"}, bus_if.B_MDO, 32'h0);
        chk({tag, " A_ACK"}, {31'h0, bus_if.A_ACK}, 32'h0);
        chk({tag, " B_ACK"}, {31'h0, bus_if.B_ACK}, 32'h0);
        chk({tag, " ERR"}, {30'h0, ERR}, 32'h0);
        chk({tag, " BUSY"}, {31'h0, BUSY}, 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RSTN        = 1'b0;
        ERR_CLR     = 1'b0;
        bus_if.A_MAD = '0; bus_if.A_MDI = '0; bus_if.A_MBE = '0;
        bus_if.A_MWE = 1'b0; bus_if.A_MRE = 1'b0;
        bus_if.B_MAD = '0; bus_if.B_MDI = '0; bus_if.B_MBE = '0;
        bus_if.B_MWE = 1'b0; bus_if.B_MRE = 1'b0;
        bus_if.BUS_MDO = 32'hDEADBEEF;

        // Reset state
        tick(); tick();
        chk_reset_vals("rst");
        RSTN = 1'b1;
        tick(); tick();

        // Simultaneous A/B writes after reset: A first
        bus_if.A_MAD = 16'h0100; bus_if.A_MDI = 32'h11111111; bus_if.A_MBE = 32'hFFFFFFFF;
        bus_if.B_MAD = 16'h0200; bus_if.B_MDI = 32'h22222222; bus_if.B_MBE = 32'h0000FFFF;
        bus_if.A_MWE = 1'b1; bus_if.B_MWE = 1'b1;
        tick();  // t+1
        bus_if.A_MWE = 1'b0; bus_if.B_MWE = 1'b0;
        tick();  // t+2
        chk("pair1 t2 MWE", {31'h0, bus_if.BUS_MWE}, 32'h1);
        chk("pair1 t2 MAD", {16'h0, bus_if.BUS_MAD}, 32'h0100);
        tick();  // t+3
        chk("pair1 t3 A_ACK", {31'h0, bus_if.A_ACK}, 32'h1);
        chk("pair1 t3 B_ACK", {31'h0, bus_if.B_ACK}, 32'h0);
        tick();  // t+4
        chk("pair1 t4 MWE", {31'h0, bus_if.BUS_MWE}, 32'h0);
        tick();  // t+5
        chk("pair1 t5 MWE", {31'h0, bus_if.BUS_MWE}, 32'h1);
        chk("pair1 t5 MAD", {16'h0, bus_if.BUS_MAD}, 32'h0200);
        chk("pair1 t5 MDI", bus_if.BUS_MDI, 32'h22222222);
        tick();  // t+6
        chk("pair1 t6 B_ACK", {31'h0, bus_if.B_ACK}, 32'h1);
        chk("pair1 t6 A_ACK", {31'h0, bus_if.A_ACK}, 32'h0);
        tick(); tick();

        // Single write on A; input address changes after the pulse
        bus_if.A_MAD = 16'h0012; bus_if.A_MDI = 32'hCAFE0001; bus_if.A_MBE = 32'h00FF00FF;
        bus_if.A_MWE = 1'b1;
        tick();  // t+1
        bus_if.A_MWE = 1'b0; bus_if.A_MAD = 16'h7777; bus_if.A_MDI = 32'h0;
        chk("wrA t1 MWE", {31'h0, bus_if.BUS_MWE}, 32'h0);
        chk("wrA t1 BUSY", {31'h0, BUSY}, 32'h0);
        tick();  // t+2
        chk("wrA t2 MWE", {31'h0, bus_if.BUS_MWE}, 32'h1);
        chk("wrA t2 MRE", {31'h0, bus_if.BUS_MRE}, 32'h0);
        chk("wrA t2 MAD", {16'h0, bus_if.BUS_MAD}, 32'h0012);
        chk("wrA t2 MDI", bus_if.BUS_MDI, 32'hCAFE0001);
        chk("wrA t2 MBE", bus_if.BUS_MBE, 32'h00FF00FF);
        chk("wrA t2 BUSY", {31'h0, BUSY}, 32'h1);
        chk("wrA t2 A_ACK", {31'h0, bus_if.A_ACK}, 32'h0);
        tick();  // t+3
        chk("wrA t3 A_ACK", {31'h0, bus_if.A_ACK}, 32'h1);
        chk("wrA t3 B_ACK", {31'h0, bus_if.B_ACK}, 32'h0);
        chk("wrA t3 MWE", {31'h0, bus_if.BUS_MWE}, 32'h0);
        tick();  // t+4
        chk("wrA t4 A_ACK", {31'h0, bus_if.A_ACK}, 32'h0);
        chk("wrA t4 BUSY", {31'h0, BUSY}, 32'h0);
        tick();

        // Pair again; last grant was A so B goes first
        bus_if.A_MAD = 16'h0110; bus_if.A_MDI = 32'h33333333;
        bus_if.B_MAD = 16'h0220; bus_if.B_MDI = 32'h44444444;
        bus_if.A_MWE = 1'b1; bus_if.B_MWE = 1'b1;
        tick();  // t+1
        bus_if.A_MWE = 1'b0; bus_if.B_MWE = 1'b0;
        tick();  // t+2
        chk("pair2 t2 MAD", {16'h0, bus_if.BUS_MAD}, 32'h0220);
        chk("pair2 t2 MWE", {31'h0, bus_if.BUS_MWE}, 32'h1);
        tick();  // t+3
        chk("pair2 t3 B_ACK", {31'h0, bus_if.B_ACK}, 32'h1);
        chk("pair2 t3 A_ACK", {31'h0, bus_if.A_ACK}, 32'h0);
        tick(); tick();  // t+5
        chk("pair2 t5 MAD", {16'h0, bus_if.BUS_MAD}, 32'h0110);
        chk("pair2 t5 MWE", {31'h0, bus_if.BUS_MWE}, 32'h1);
        tick();  // t+6
        chk("pair2 t6 A_ACK", {31'h0, bus_if.A_ACK}, 32'h1);
        tick(); tick();

        // Read on B, RD_LAT = 3; bus data valid only in t+5
        bus_if.B_MAD = 16'h0040; bus_if.B_MBE = 32'hFFFFFFFF; bus_if.B_MRE = 1'b1;
        tick();  // t+1
        bus_if.B_MRE = 1'b0;
        tick();  // t+2
        chk("rdB t2 MRE", {31'h0, bus_if.BUS_MRE}, 32'h1);
        chk("rdB t2 MWE", {31'h0, bus_if.BUS_MWE}, 32'h0);
        chk("rdB t2 MBE", bus_if.BUS_MBE, 32'h0);
        chk("rdB t2 MAD", {16'h0, bus_if.BUS_MAD}, 32'h0040);
        tick();  // t+3
        chk("rdB t3 MRE", {31'h0, bus_if.BUS_MRE}, 32'h0);
        chk("rdB t3 BUSY", {31'h0, BUSY}, 32'h1);
        tick();  // t+4
        chk("rdB t4 B_ACK", {31'h0, bus_if.B_ACK}, 32'h0);
        tick();  // t+5
        bus_if.BUS_MDO = 32'h5A5A1234;
        chk("rdB t5 B_ACK", {31'h0, bus_if.B_ACK}, 32'h0);
        chk("rdB t5 B_MDO", bus_if.B_MDO, 32'h0);
        tick();  // t+6
        bus_if.BUS_MDO = 32'hDEADBEEF;
        chk("rdB t6 B_ACK", {31'h0, bus_if.B_ACK}, 32'h1);
        chk("rdB t6 B_MDO", bus_if.B_MDO, 32'h5A5A1234);
        chk("rdB t6 A_MDO", bus_if.A_MDO, 32'h0);
        tick();  // t+7
        chk("rdB t7 B_ACK", {31'h0, bus_if.B_ACK}, 32'h0);
        chk("rdB t7 B_MDO", bus_if.B_MDO, 32'h5A5A1234);
        chk("rdB t7 BUSY", {31'h0, BUSY}, 32'h0);
        tick();

        // Second A pulse while the first is still pending
        bus_if.A_MAD = 16'h0300; bus_if.A_MDI = 32'h55555555; bus_if.A_MWE = 1'b1;
        tick();  // t+1
        bus_if.A_MAD = 16'h0304; bus_if.A_MDI = 32'h66666666;
        chk("drop t1 ERR", {30'h0, ERR}, 32'h0);
        tick();  // t+2
        bus_if.A_MWE = 1'b0;
        chk("drop t2 ERR", {30'h0, ERR}, 32'h1);
        chk("drop t2 MWE", {31'h0, bus_if.BUS_MWE}, 32'h1);
        chk("drop t2 MAD", {16'h0, bus_if.BUS_MAD}, 32'h0300);
        tick();  // t+3
        chk("drop t3 A_ACK", {31'h0, bus_if.A_ACK}, 32'h1);
        for (int i = 4; i < 8; i++) begin
            tick();
            chk($sformatf("drop t%0d MWE", i), {31'h0, bus_if.BUS_MWE}, 32'h0);
        end
        chk("drop sticky ERR", {30'h0, ERR}, 32'h1);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        chk("drop clr ERR", {30'h0, ERR}, 32'h0);
        tick();

        // MWE and MRE together on B: one write, ERR[1]
        bus_if.B_MAD = 16'h0400; bus_if.B_MDI = 32'h77777777; bus_if.B_MBE = 32'h000000FF;
        bus_if.B_MWE = 1'b1; bus_if.B_MRE = 1'b1;
        tick();  // t+1
        bus_if.B_MWE = 1'b0; bus_if.B_MRE = 1'b0;
        chk("both t1 ERR", {30'h0, ERR}, 32'h2);
        tick();  // t+2
        chk("both t2 MWE", {31'h0, bus_if.BUS_MWE}, 32'h1);
        chk("both t2 MRE", {31'h0, bus_if.BUS_MRE}, 32'h0);
        chk("both t2 MDI", bus_if.BUS_MDI, 32'h77777777);
        chk("both t2 MBE", bus_if.BUS_MBE, 32'h000000FF);
        tick();  // t+3
        chk("both t3 B_ACK", {31'h0, bus_if.B_ACK}, 32'h1);
        for (int i = 4; i < 7; i++) begin
            tick();
            chk($sformatf("both t%0d MRE", i), {31'h0, bus_if.BUS_MRE}, 32'h0);
            chk($sformatf("both t%0d MWE", i), {31'h0, bus_if.BUS_MWE}, 32'h0);
        end
        chk("both ERR", {30'h0, ERR}, 32'h2);

        // Read on A, reset asserted during WAIT
        bus_if.A_MAD = 16'h0500; bus_if.A_MRE = 1'b1;
        tick();  // t+1
        bus_if.A_MRE = 1'b0;
        tick();  // t+2
        chk("rst t2 MRE", {31'h0, bus_if.BUS_MRE}, 32'h1);
        tick();  // t+3, WAIT
        chk("rst t3 BUSY", {31'h0, BUSY}, 32'h1);
        RSTN = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        RSTN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("post %0d A_ACK", i), {31'h0, bus_if.A_ACK}, 32'h0);
            chk($sformatf("post %0d MRE", i), {31'h0, bus_if.BUS_MRE}, 32'h0);
        end
        chk("post BUSY", {31'h0, BUSY}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
